// File: rtl/rtc_pkg.sv
// Shared RTC timing definitions: key-period FSM states, default clock and
// key-period constants (also used by the divider and keygen), and the
// key-period cycle helper.
package rtc_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    STALE    = 2'd2
  } rtc_state_t;

  localparam int unsigned RTC_KEYCHANGE_PERIOD = 5;
  localparam int unsigned RTC_SYS_CLK_HZ       = 1000000;

  // Number of sys_clk cycles in one key period.
  function automatic int unsigned key_cycles(input int unsigned hz, input int unsigned period);
    return hz * period;
  endfunction

endpackage

// File: rtl/rtc_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one divided RTC clock.
// Emits a registered one-cycle tick per rising edge. The detector only arms
// once a genuine low has come through the synchroniser, so an input that is
// already high at reset release does not produce a spurious tick.
module rtc_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic tick_o
);

  logic       s1_q, s2_q, prev_q, armed_q, tick_q;
  logic [1:0] fill_q;
  logic       armed_d, tick_d;

  // Arm on a low from a filled synchroniser; the post-reset zeros in s2 are not a real sample.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & ~s2_q);
    tick_d  = s2_q & ~prev_q & armed_q;
  end

  // Synchroniser, history, arming and tick registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= sig_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/rtc_tick_sync.sv
// RTC tick synchroniser: brings clk_500Hz / clk_5s into sys_clk as one-cycle
// ticks, keeps the OTP key time-step counter and supervises the key clock.
// Optional feature macro: RTC_WATCHDOG_EN enables the key-period watchdog
// (wd_cnt and the STALE state). Without it, stale stays 0 and the FSM latches
// LOCKED on the first key tick until reset.
//
// state    | meaning
// UNLOCKED | no key tick seen since reset
// LOCKED   | key tick seen within the last WD_LIMIT cycles
// STALE    | key clock overdue (watchdog build only)
module rtc_tick_sync
  import rtc_pkg::*;
#(
  parameter int unsigned KEYCHANGE_PERIOD = RTC_KEYCHANGE_PERIOD,
  parameter int unsigned SYS_CLK_HZ       = RTC_SYS_CLK_HZ,
  parameter int unsigned TS_WIDTH         = 32,
  parameter int unsigned WD_SLACK         = 1000
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                clk_500Hz,
  input  logic                clk_5s,
  input  logic                ts_load,
  input  logic [TS_WIDTH-1:0] ts_load_val,
  output logic                tick_500Hz,
  output logic                tick_key,
  output logic [TS_WIDTH-1:0] timestep,
  output logic                locked,
  output logic                stale
);

  localparam int unsigned KEY_CYCLES = key_cycles(SYS_CLK_HZ, KEYCHANGE_PERIOD);
  localparam int unsigned WD_LIMIT   = KEY_CYCLES + WD_SLACK;

  rtc_state_t          state_q, state_d;
  logic [TS_WIDTH-1:0] timestep_q, timestep_d;
  logic                locked_q, stale_q;
  logic                wd_hit;

  rtc_edge_sync u_sync_500hz (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .sig_i  (clk_500Hz),
    .tick_o (tick_500Hz)
  );

  rtc_edge_sync u_sync_key (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .sig_i  (clk_5s),
    .tick_o (tick_key)
  );

`ifdef RTC_WATCHDOG_EN
  localparam int unsigned     WD_W   = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Cycles since the last key tick, saturating at the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (tick_key) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Flag on the edge where the count lands on the limit, so stale rises
  // exactly WD_LIMIT cycles after the edge that closed the last tick.
  assign wd_hit = (wd_cnt_d == WD_MAX);
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = (WD_LIMIT == 0);
  assign wd_hit        = 1'b0;
`endif

  // Time-step: a load beats a same-cycle key tick; increment wraps naturally.
  always_comb begin
    timestep_d = timestep_q;
    if (ts_load) begin
      timestep_d = ts_load_val;
    end else if (tick_key) begin
      timestep_d = timestep_q + TS_WIDTH'(1);
    end
  end

  // Lock/stale next state; a key tick wins over a same-cycle limit hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: begin
        if (tick_key)    state_d = LOCKED;
        else if (wd_hit) state_d = STALE;
      end
      LOCKED: begin
        if (!tick_key && wd_hit) state_d = STALE;
      end
      STALE: begin
        if (tick_key) state_d = LOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // State, time-step and registered status outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      timestep_q <= '0;
      locked_q   <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timestep_q <= timestep_d;
      locked_q   <= (state_d == LOCKED);
      stale_q    <= (state_d == STALE);
    end
  end

  assign timestep = timestep_q;
  assign locked   = locked_q;
  assign stale    = stale_q;

endmodule

// File: tb/tb_rtc_tick_sync.sv
// Testbench for rtc_tick_sync with small simulation timing (WD_LIMIT = 110).
// A cycle-level reference model, written from the edge/tick/watchdog rules,
// runs alongside the DUT and is compared every cycle; directed sequences and a
// vector table cover the corner cases with hand-derived constants.
module tb_rtc_tick_sync;

  localparam int unsigned HZ       = 100;
  localparam int unsigned PERIOD   = 1;
  localparam int unsigned SLACK    = 10;
  localparam int unsigned WD_LIMIT = HZ * PERIOD + SLACK;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_500Hz = 1'b0;
  logic        clk_5s = 1'b0;
  logic        ts_load = 1'b0;
  logic [31:0] ts_load_val = '0;
  logic        tick_500Hz, tick_key, locked, stale;
  logic [31:0] timestep;

  int n_tot = 0;
  int n_pass = 0;

  rtc_tick_sync #(
    .KEYCHANGE_PERIOD (PERIOD),
    .SYS_CLK_HZ       (HZ),
    .TS_WIDTH         (32),
    .WD_SLACK         (SLACK)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .clk_500Hz   (clk_500Hz),
    .clk_5s      (clk_5s),
    .ts_load     (ts_load),
    .ts_load_val (ts_load_val),
    .tick_500Hz  (tick_500Hz),
    .tick_key    (tick_key),
    .timestep    (timestep),
    .locked      (locked),
    .stale       (stale)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_edges;
  int          e;
  int unsigned m_since, ns;
  logic        m_k_last, m_h_last, m_tk, m_th, m_lock, m_stale;
  logic [31:0] m_ts;
  int          due_k[$];
  int          due_h[$];

  // A rising edge is a high sample whose previous post-reset sample was low;
  // its tick occupies the cycle after the edge two edges later.
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_edges <= 0; m_k_last <= 1'b0; m_h_last <= 1'b0;
      m_tk <= 1'b0; m_th <= 1'b0; m_ts <= '0;
      m_lock <= 1'b0; m_stale <= 1'b0; m_since <= 0;
      due_k.delete(); due_h.delete();
    end else begin
      e = m_edges + 1;
      if (ts_load) m_ts <= ts_load_val;
      else if (m_tk) m_ts <= m_ts + 32'd1;
      if (m_tk) begin
        m_since <= 0; m_lock <= 1'b1; m_stale <= 1'b0;
      end else begin
        ns = (m_since < WD_LIMIT) ? m_since + 1 : m_since;
        m_since <= ns;
`ifdef RTC_WATCHDOG_EN
        if (ns == WD_LIMIT) begin m_stale <= 1'b1; m_lock <= 1'b0; end
`endif
      end
      m_tk <= (due_k.size() > 0 && due_k[0] == e);
      if (due_k.size() > 0 && due_k[0] == e) due_k.delete(0);
      m_th <= (due_h.size() > 0 && due_h[0] == e);
      if (due_h.size() > 0 && due_h[0] == e) due_h.delete(0);
      if (e >= 2 && clk_5s && !m_k_last) due_k.push_back(e + 2);
      if (e >= 2 && clk_500Hz && !m_h_last) due_h.push_back(e + 2);
      m_k_last <= clk_5s;
      m_h_last <= clk_500Hz;
      m_edges  <= e;
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge sys_clk) begin
    chk("scoreboard", {28'd0, tick_500Hz, tick_key, locked, stale, timestep},
        {28'd0, m_th, m_tk, m_lock, m_stale, m_ts});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic key_pulse();
    clk_5s = 1'b0;
    repeat (4) cyc();
    clk_5s = 1'b1;
    repeat (4) cyc();
  endtask

  typedef struct {
    logic        ld;
    logic [31:0] val;
    int          n_keys;
    logic [31:0] exp_ts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, cnt, run, max_run;
    int kh, hh;
    logic saw;

    vecs[0] = '{1'b1, 32'h0000_0010, 0, 32'h0000_0010};
    vecs[1] = '{1'b0, 32'h0,         3, 32'h0000_0013};
    vecs[2] = '{1'b1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'h0,         1, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 2, 32'h0000_0001};
    vecs[5] = '{1'b1, 32'h1234_5678, 0, 32'h1234_5678};

    // Reset values.
    do_reset();
    chk("reset_outputs", {tick_500Hz, tick_key, locked, stale, timestep}, 36'd0);

    // First key edge: sampled at edge 20, tick after edge 22 only.
    repeat (19) cyc();
    clk_5s = 1'b1;
    cyc(); chk("t1_tick_e20", tick_key, 0);
    cyc(); chk("t1_tick_e21", tick_key, 0);
    cyc(); chk("t1_tick_e22", tick_key, 1);
    chk("t1_ts_during_tick", timestep, 0);
    chk("t1_locked_during_tick", locked, 0);
    cyc(); chk("t1_tick_e23", tick_key, 0);
    chk("t1_ts_after", timestep, 1);
    chk("t1_locked_after", locked, 1);

`ifdef RTC_WATCHDOG_EN
    // Stale exactly WD_LIMIT edges after the edge that closed the tick.
    n = 0;
    while (!stale && n < 300) begin cyc(); n++; end
    chk("t3_stale_delay", n, WD_LIMIT);
    chk("t3_locked_when_stale", locked, 0);
    key_pulse();
    chk("t3_relock", {locked, stale}, 2'b10);
    chk("t3_ts_after_relock", timestep, 2);
`else
    repeat (200) cyc();
    chk("t3_hold_locked", {locked, stale}, 2'b10);
`endif

    // Load beats a same-cycle key tick, then wrap.
    clk_5s = 1'b0;
    repeat (4) cyc();
    clk_5s = 1'b1;
    n = 0;
    while (!tick_key && n < 10) begin cyc(); n++; end
    chk("t4_tick_seen", tick_key, 1);
    ts_load = 1'b1;
    ts_load_val = 32'hFFFF_FFFE;
    cyc();
    ts_load = 1'b0;
    chk("t4_load_wins", timestep, 32'hFFFF_FFFE);
    key_pulse(); chk("t4_ts_ffffffff", timestep, 32'hFFFF_FFFF);
    key_pulse(); chk("t4_ts_wrap", timestep, 32'h0);

    // Vector table: optional load then N key edges.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ld) begin
        ts_load = 1'b1;
        ts_load_val = vecs[i].val;
        cyc();
        ts_load = 1'b0;
      end
      for (int k = 0; k < vecs[i].n_keys; k++) key_pulse();
      chk($sformatf("vec%0d_ts", i), timestep, vecs[i].exp_ts);
    end

    // 500 Hz ticks: 5 periods of 20 cycles right after a fresh key tick.
    key_pulse();
    cnt = 0; run = 0; max_run = 0;
    for (int p = 0; p < 5; p++) begin
      clk_500Hz = 1'b1;
      for (int c = 0; c < 10; c++) begin
        cyc();
        if (tick_500Hz) begin cnt++; run++; end else run = 0;
        if (run > max_run) max_run = run;
      end
      clk_500Hz = 1'b0;
      for (int c = 0; c < 10; c++) begin
        cyc();
        if (tick_500Hz) begin cnt++; run++; end else run = 0;
        if (run > max_run) max_run = run;
      end
    end
    repeat (4) begin
      cyc();
      if (tick_500Hz) cnt++;
    end
    chk("t5_tick500_count", cnt, 5);
    chk("t5_tick500_width", max_run, 1);
    chk("t5_status_unchanged", {locked, stale}, 2'b10);

    // Key input high through reset release: no tick until a low is seen.
    clk_5s = 1'b1;
    do_reset();
    cnt = 0;
    repeat (10) begin cyc(); if (tick_key) cnt++; end
    chk("t2_no_tick_high_at_reset", cnt, 0);
    clk_5s = 1'b0;
    repeat (5) cyc();
    clk_5s = 1'b1;
    cnt = 0;
    repeat (10) begin cyc(); if (tick_key) cnt++; end
    chk("t2_one_tick", cnt, 1);
    chk("t2_locked", locked, 1);

    // Randomised traffic against the model.
    kh = 1; hh = 1;
    for (int i = 0; i < 4000; i++) begin
      kh = kh - 1;
      if (kh == 0) begin clk_5s = ~clk_5s; kh = $urandom_range(1, 140); end
      hh = hh - 1;
      if (hh == 0) begin clk_500Hz = ~clk_500Hz; hh = $urandom_range(1, 12); end
      ts_load = ($urandom_range(0, 31) == 0);
      ts_load_val = $urandom;
      cyc();
    end
    ts_load = 1'b0;
    clk_5s = 1'b0;
    clk_500Hz = 1'b0;

    // Async reset mid period with timestep = 7.
    ts_load = 1'b1;
    ts_load_val = 32'd7;
    cyc();
    ts_load = 1'b0;
`ifdef RTC_WATCHDOG_EN
    repeat (WD_LIMIT + 5) cyc();
    chk("t6_stale_before_rst", stale, 1);
`endif
    chk("t6_ts_before_rst", timestep, 7);
    @(posedge sys_clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_clear", {tick_500Hz, tick_key, locked, stale, timestep}, 36'd0);
    cyc();
    cyc();
    rst = 1'b0;
`ifndef RTC_WATCHDOG_EN
    saw = 1'b0;
    repeat (500) begin cyc(); if (stale) saw = 1'b1; end
    chk("t6_no_stale_idle", saw, 0);
    chk("t6_unlocked_idle", locked, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
